// File: rtl/riscv_io_pkg.sv
`default_nettype none
// ============================================================================
// Package     : riscv_io_pkg
// Description : Shared offsets and status-bit layout for the memory-mapped
//               I/O block that sits beside dmem in the memory stage.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_io_pkg;

  // Register offsets (addr[7:0]) inside the I/O window
  localparam logic [7:0] IO_STATUS = 8'h00;  // R : {rx_nonempty, tx_idle}
  localparam logic [7:0] IO_RX     = 8'h04;  // R : RX FIFO head, pops
  localparam logic [7:0] IO_TX     = 8'h08;  // W : TX holding register
  localparam logic [7:0] IO_CYC    = 8'h10;  // R : cycle counter
  localparam logic [7:0] IO_INST   = 8'h14;  // R : retired-instruction counter
  localparam logic [7:0] IO_CLR    = 8'h18;  // W : clears both counters

  // Bit positions inside the status word
  localparam int unsigned STAT_TX_IDLE  = 0;  // 1 when a new TX byte is accepted
  localparam int unsigned STAT_RX_AVAIL = 1;  // 1 when the RX FIFO holds data

endpackage : riscv_io_pkg
`default_nettype wire

// File: rtl/io_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : io_rx_fifo
// Description : Byte-wide receive FIFO for the UART path. Power-of-two depth,
//               wrapping pointers, occupancy counter one bit wider than the
//               pointers. Push is refused when full, pop ignored when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module io_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,      // asynchronous, active-low
  input  logic       push_i,
  input  logic [7:0] din_i,
  output logic       full_o,
  input  logic       pop_i,
  output logic [7:0] dout_o,
  output logic       empty_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [7:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic w_do_push;
  logic w_do_pop;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign w_do_push = push_i & ~full_o;
  assign w_do_pop  = pop_i & ~empty_o;
  assign dout_o    = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; reset discards any stored bytes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care while the count says empty
  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule : io_rx_fifo
`default_nettype wire

// File: rtl/io_mmio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : io_mmio_ctrl
// Description : Memory-mapped I/O controller beside dmem. Decodes stage-2
//               loads/stores into the UART TX register, the RX FIFO and the
//               cycle / retired-instruction counters. Load data is
//               registered so it lines up with dmem data in stage 3.
// Revision    : 1.0 - initial release
// ============================================================================
module io_mmio_ctrl
  import riscv_io_pkg::*;
#(
  parameter int         RX_DEPTH = 8,
  parameter logic [3:0] IO_BASE  = 4'h8
) (
  input  logic        clk,
  input  logic        rst,            // asynchronous, active-low
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  input  logic        stall,
  input  logic        inst_retired,
  output logic [31:0] rdata,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  // --------------------------------------------------------------------------
  // Address decode and access qualification
  // --------------------------------------------------------------------------
  logic       w_sel;
  logic [7:0] w_off;
  logic       w_acc_re;
  logic       w_acc_we;
  logic       w_unused_bits;

  assign w_sel    = (addr[31:28] == IO_BASE);
  assign w_off    = addr[7:0];
  assign w_acc_re = re & w_sel & ~stall;
  assign w_acc_we = we & w_sel & ~stall;

  // Address bits between the window select and the offset are don't-care,
  // and only the low byte of store data is ever consumed.
  assign w_unused_bits = ^{addr[27:8], wdata[31:8]};

  // --------------------------------------------------------------------------
  // RX FIFO
  // --------------------------------------------------------------------------
  logic       w_fifo_full;
  logic       w_fifo_empty;
  logic [7:0] w_fifo_dout;
  logic       w_fifo_pop;

  assign uart_rx_ready = ~w_fifo_full;
  assign w_fifo_pop    = w_acc_re & (w_off == IO_RX);

  io_rx_fifo #(
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (uart_rx_valid),
    .din_i   (uart_rx_data),
    .full_o  (w_fifo_full),
    .pop_i   (w_fifo_pop),
    .dout_o  (w_fifo_dout),
    .empty_o (w_fifo_empty)
  );

  // --------------------------------------------------------------------------
  // TX holding register
  // --------------------------------------------------------------------------
  logic       tx_pending_q;
  logic [7:0] tx_buf_q;
  logic       w_tx_hs;
  logic       w_tx_load;

  assign w_tx_hs       = tx_pending_q & uart_tx_ready;
  // A write is only accepted into an empty holding register; a write landing
  // on the handshake cycle sees pending=1 and is dropped, software re-polls.
  assign w_tx_load     = w_acc_we & (w_off == IO_TX) & ~tx_pending_q;
  assign uart_tx_valid = tx_pending_q;
  assign uart_tx_data  = tx_buf_q;

  // Pending flag clears on handshake, sets on an accepted write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_pending_q <= 1'b0;
      tx_buf_q     <= 8'h00;
    end else if (w_tx_hs) begin
      tx_pending_q <= 1'b0;
    end else if (w_tx_load) begin
      tx_pending_q <= 1'b1;
      tx_buf_q     <= wdata[7:0];
    end
  end

  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;
  logic        w_clr;

  assign w_clr = w_acc_we & (w_off == IO_CLR);

  // Clear has priority over the free-running increments
  always_comb begin
    cycle_cnt_d = cycle_cnt_q + 32'd1;
    instr_cnt_d = instr_cnt_q + {31'd0, inst_retired};
    if (w_clr) begin
      cycle_cnt_d = 32'd0;
      instr_cnt_d = 32'd0;
    end
  end

  // Counter state; cycle counter also advances through stalls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt_q <= 32'd0;
      instr_cnt_q <= 32'd0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Read mux and registered load data
  // --------------------------------------------------------------------------
  logic [31:0] rdata_q, rdata_d;

  // Capture read data only on a qualified load; otherwise hold
  always_comb begin
    rdata_d = rdata_q;
    if (w_acc_re) begin
      rdata_d = 32'd0;
      case (w_off)
        IO_STATUS: begin
          rdata_d[STAT_TX_IDLE]  = ~tx_pending_q;
          rdata_d[STAT_RX_AVAIL] = ~w_fifo_empty;
        end
        IO_RX:     rdata_d = w_fifo_empty ? 32'd0 : {24'd0, w_fifo_dout};
        IO_CYC:    rdata_d = cycle_cnt_q;
        IO_INST:   rdata_d = instr_cnt_q;
        default:   rdata_d = 32'd0;
      endcase
    end
  end

  // Load-data register, aligned with dmem output in stage 3
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata_q <= 32'd0;
    else      rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule : io_mmio_ctrl
`default_nettype wire
